fwd_scoreboard: RTL

- Parametrised hazard scoreboard and forwarding-select unit for the N-issue SPU core. Generalises the fixed two-pipe even/odd stall-OR and forwarding arrangement.
- Tracks in-flight destination registers per issue lane in DEPTH-stage shift registers. Each entry carries a per-instruction result latency.
- Produces per-lane in-order RAW stalls, per-source forward selects (lane, stage), branch-kill of issued slots, and a saturating stall counter.
- Sits between decode/issue and the pipes' forwarding muxes.

---
 rtl/spu_pkg.sv | 24 ++
 rtl/sb_lane_shift.sv | 58 +++++
 rtl/fwd_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions for the forwarding scoreboard.
//   sb_entry_t : one in-flight destination record {v, addr, lat}
//   LAT_*      : default result latencies (in pipeline stages) per execution unit
package spu_pkg;

  // Entries carry a fixed-width address so the type stays independent of any
  // one instance's ADDR_W. Narrower addresses are zero-extended into it.
  localparam int SB_ADDR_MAX = 16;
  localparam int SB_LAT_W    = 3;

  typedef struct packed {
    logic                   v;
    logic [SB_ADDR_MAX-1:0] addr;
    logic [SB_LAT_W-1:0]    lat;
  } sb_entry_t;

  localparam logic [SB_LAT_W-1:0] LAT_FX   = 3'd2;
  localparam logic [SB_LAT_W-1:0] LAT_BYTE = 3'd4;
  localparam logic [SB_LAT_W-1:0] LAT_FP   = 3'd6;
  localparam logic [SB_LAT_W-1:0] LAT_PERM = 3'd4;
  localparam logic [SB_LAT_W-1:0] LAT_LS   = 3'd6;
  localparam logic [SB_LAT_W-1:0] LAT_BR   = 3'd1;

endpackage

// File: rtl/sb_lane_shift.sv
// One issue lane's in-flight destination tracker: a DEPTH-stage shift register
// of sb_entry_t that advances every cycle and never freezes.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (clears valid bits only)
//   load_i  entry entering stage 1 on the next clock (v=0 for a bubble)
//   kill_i  squash the entry currently resident in stage 1
//   ent_o   current entries, index 0 = stage 1; stage-1 valid already has kill applied
module sb_lane_shift
  import spu_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  sb_entry_t             load_i,
  input  logic                  kill_i,
  output sb_entry_t [DEPTH-1:0] ent_o
);

  logic [DEPTH-1:0]                   v_q,    v_d;
  logic [DEPTH-1:0][SB_ADDR_MAX-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][SB_LAT_W-1:0]     lat_q,  lat_d;

  // Kill acts on the resident stage-1 entry before both lookup and shift, so
  // a killed entry is invisible downstream for its whole remaining lifetime.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      ent_o[s].v    = v_q[s];
      ent_o[s].addr = addr_q[s];
      ent_o[s].lat  = lat_q[s];
    end
    ent_o[0].v = v_q[0] & ~kill_i;
  end

  always_comb begin
    v_d[0]    = load_i.v;
    addr_d[0] = load_i.addr;
    lat_d[0]  = load_i.lat;
    for (int s = 1; s < DEPTH; s++) begin
      v_d[s]    = ent_o[s-1].v;
      addr_d[s] = ent_o[s-1].addr;
      lat_d[s]  = ent_o[s-1].lat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) v_q <= '0;
    else         v_q <= v_d;
  end

  // Payload is meaningless while v=0, so it needs no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    lat_q  <= lat_d;
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// N-issue RAW hazard scoreboard and forwarding-select unit.
// Tracks destination registers in flight per lane, stalls lanes in order on
// unresolved RAW hazards, and selects the youngest ready producer per source.
// Ports:
//   clk, reset (async, active-low)
//   iss_valid/iss_wr/iss_rt/iss_lat  issue group, lane 0 oldest
//   src_valid/src_addr               source operands, index lane*NSRC+src
//   kill                             squash the stage-1 entry of a lane
//   stall                            lane not accepted this cycle
//   fwd_hit/fwd_lane/fwd_stage       forwarding select per source
//   stall_cnt                        saturating count of cycles with any stall
module fwd_scoreboard
  import spu_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int NSRC   = 3,
  parameter int CNT_W  = 16,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int STG_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              iss_valid,
  input  logic [LANES-1:0]              iss_wr,
  input  logic [LANES*ADDR_W-1:0]       iss_rt,
  input  logic [LANES*3-1:0]            iss_lat,
  input  logic [LANES*NSRC-1:0]         src_valid,
  input  logic [LANES*NSRC*ADDR_W-1:0]  src_addr,
  input  logic [LANES-1:0]              kill,
  output logic [LANES-1:0]              stall,
  output logic [LANES*NSRC-1:0]         fwd_hit,
  output logic [LANES*NSRC*LANE_W-1:0]  fwd_lane,
  output logic [LANES*NSRC*STG_W-1:0]   fwd_stage,
  output logic [CNT_W-1:0]              stall_cnt
);

  sb_entry_t [DEPTH-1:0] ent [LANES];
  sb_entry_t [LANES-1:0] ld;
  logic [LANES-1:0]      hazard;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sb_lane_shift #(.DEPTH(DEPTH)) u_shift (
      .clk_i  (clk),
      .rst_ni (reset),
      .load_i (ld[l]),
      .kill_i (kill[l]),
      .ent_o  (ent[l])
    );
  end

  // Lookup: scan oldest-to-youngest so the last match (smallest stage, then
  // highest lane within a stage) is the youngest producer and wins.
  always_comb begin
    logic                   found;
    logic                   rdy;
    logic [LANE_W-1:0]      wl;
    logic [STG_W-1:0]       ws;
    logic [SB_ADDR_MAX-1:0] sa;
    int                     idx;
    hazard    = '0;
    fwd_hit   = '0;
    fwd_lane  = '0;
    fwd_stage = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < NSRC; k++) begin
        idx   = l * NSRC + k;
        sa    = SB_ADDR_MAX'(src_addr[idx*ADDR_W +: ADDR_W]);
        found = 1'b0;
        rdy   = 1'b0;
        wl    = '0;
        ws    = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          for (int m = 0; m < LANES; m++) begin
            if (ent[m][s].v && ent[m][s].addr == sa) begin
              found = 1'b1;
              rdy   = (s + 1) >= int'(ent[m][s].lat);
              wl    = LANE_W'(m);
              ws    = STG_W'(s + 1);
            end
          end
        end
        if (reset && src_valid[idx]) begin
          if (found && rdy) begin
            fwd_hit[idx]                   = 1'b1;
            fwd_lane[idx*LANE_W +: LANE_W] = wl;
            fwd_stage[idx*STG_W +: STG_W]  = ws;
          end else if (found) begin
            hazard[l] = 1'b1;
          end
          // A producer in an older lane of the same group is not in flight
          // yet, so it can never be forwarded this cycle.
          for (int i = 0; i < l; i++) begin
            if (iss_valid[i] && iss_wr[i] &&
                SB_ADDR_MAX'(iss_rt[i*ADDR_W +: ADDR_W]) == sa)
              hazard[l] = 1'b1;
          end
        end
      end
    end
  end

  // In-order issue: once a lane stalls, every younger lane stalls too.
  always_comb begin
    logic run;
    run   = 1'b0;
    stall = '0;
    for (int i = 0; i < LANES; i++) begin
      run      = run | hazard[i];
      stall[i] = run & reset;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ld[l].v    = iss_valid[l] & iss_wr[l] & ~stall[l];
      ld[l].addr = SB_ADDR_MAX'(iss_rt[l*ADDR_W +: ADDR_W]);
      ld[l].lat  = iss_lat[l*3 +: 3];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule
